// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store-drain FIFO between the MEM stage and the data memory port
//
// Queues committed stores and drains them one per cycle into the data memory
// whenever a load does not need the port. Loads whose word index matches a
// pending store are stalled until that store has drained.
//
// Ports:
//   clock, reset             pipeline clock, asynchronous active-high reset
//   st_valid/st_addr/st_data/st_ls_bit, st_ready    store request from MEM
//   ld_valid/ld_addr/ld_ls_bit, ld_stall            load request from MEM
//   mem_we/mem_addr/mem_wdata/mem_ls_bit            data memory port
//   sb_count, sb_empty                              occupancy status
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_ls_bit,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    input  logic [1:0]               ld_ls_bit,
    output logic                     ld_stall,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [1:0]               mem_ls_bit,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [31:0]    addr_q [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [1:0]     size_q [DEPTH];

    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW:0]    count;

    logic [DEPTH-1:0] entry_live;
    logic [DEPTH-1:0] entry_hit;
    logic             ld_conflict;
    logic             load_grant;
    logic             push;
    logic             pop;

    // An array slot holds a queued store when its distance from head, modulo
    // DEPTH, is below the occupancy. Pointers are exactly PW bits wide, so the
    // subtraction wraps for free.
    always_comb begin
        entry_live = '0;
        entry_hit  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_live[i] = ({1'b0, PW'(i) - head} < count);
            entry_hit[i]  = entry_live[i] && (addr_q[i][11:2] == ld_addr[11:2]);
        end
    end

    // Word-index match only: a byte store into a word blocks any load of that
    // word, which is conservative but keeps the compare narrow.
    assign ld_conflict = ld_valid && (|entry_hit);
    assign ld_stall    = ld_conflict;

    assign st_ready   = (count < FULL_COUNT);
    assign push       = st_valid && st_ready;
    assign load_grant = ld_valid && !ld_conflict;
    assign pop        = !load_grant && (count != '0);

    // Port arbitration: a non-conflicting load owns the port, otherwise the
    // oldest store drains, otherwise the port idles at zero.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_ls_bit = 2'b00;
        if (load_grant) begin
            mem_addr   = ld_addr;
            mem_ls_bit = ld_ls_bit;
        end else if (count != '0) begin
            mem_we     = 1'b1;
            mem_addr   = addr_q[head];
            mem_wdata  = data_q[head];
            mem_ls_bit = size_q[head];
        end
    end

    // Entry payload carries no reset; validity comes from head/count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
            size_q[tail] <= st_ls_bit;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign sb_count = count;
    assign sb_empty = (count == '0);

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_ls_bit;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_ls_bit;
    logic        ld_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_ls_bit;
    logic [2:0]  sb_count;
    logic        sb_empty;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ls_bit  (st_ls_bit),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_ls_bit  (ld_ls_bit),
        .ld_stall   (ld_stall),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ls_bit (mem_ls_bit),
        .sb_count   (sb_count),
        .sb_empty   (sb_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain queue of pending stores in program order.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } ent_t;

    ent_t mq[$];
    bit   last_acc;

    function automatic bit model_conflict();
        bit c = 1'b0;
        foreach (mq[i]) if (mq[i].a[11:2] == ld_addr[11:2]) c = 1'b1;
        return c && ld_valid;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            last_acc = 1'b0;
        end else begin
            bit drain;
            bit acc;
            drain = !(ld_valid && !model_conflict()) && (mq.size() > 0);
            acc   = st_valid && (mq.size() < DEPTH);
            if (drain) void'(mq.pop_front());
            if (acc) mq.push_back('{a: st_addr, d: st_data, s: st_ls_bit});
            last_acc = acc;
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clock) begin
        bit          conf;
        bit          e_we;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_ls;
        conf   = model_conflict();
        e_we   = 1'b0;
        e_addr = 32'h0;
        e_data = 32'h0;
        e_ls   = 2'b00;
        if (ld_valid && !conf) begin
            e_addr = ld_addr;
            e_ls   = ld_ls_bit;
        end else if (mq.size() > 0) begin
            e_we   = 1'b1;
            e_addr = mq[0].a;
            e_data = mq[0].d;
            e_ls   = mq[0].s;
        end
        chk("m_st_ready",   32'(st_ready),   32'(mq.size() < DEPTH));
        chk("m_ld_stall",   32'(ld_stall),   32'(conf));
        chk("m_mem_we",     32'(mem_we),     32'(e_we));
        chk("m_mem_addr",   mem_addr,        e_addr);
        chk("m_mem_wdata",  mem_wdata,       e_data);
        chk("m_mem_ls_bit", 32'(mem_ls_bit), 32'(e_ls));
        chk("m_sb_count",   32'(sb_count),   32'(mq.size()));
        chk("m_sb_empty",   32'(sb_empty),   32'(mq.size() == 0));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_st(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        st_ls_bit = s;
    endtask

    task automatic set_ld(input bit v, input logic [31:0] a, input logic [1:0] s);
        ld_valid  = v;
        ld_addr   = a;
        ld_ls_bit = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int guard;
        reset = 1'b1;
        set_st(0, 0, 0, 0);
        set_ld(0, 0, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("idle_empty", 32'(sb_empty), 32'd1);
            chk("idle_ready", 32'(st_ready), 32'd1);
            chk("idle_we",    32'(mem_we),   32'd0);
            chk("idle_addr",  mem_addr,      32'h0);
            step();
        end

        // Single SW, drains the following cycle
        set_st(1, 32'h10, 32'hDEADBEEF, 2'b00);
        step();
        set_st(0, 0, 0, 0);
        @(negedge clock);
        chk("sw_we",    32'(mem_we),     32'd1);
        chk("sw_addr",  mem_addr,        32'h10);
        chk("sw_data",  mem_wdata,       32'hDEADBEEF);
        chk("sw_ls",    32'(mem_ls_bit), 32'd0);
        step();
        @(negedge clock);
        chk("sw_empty", 32'(sb_empty), 32'd1);
        step();

        // Fill while a non-conflicting load holds the port
        set_ld(1, 32'h100, 2'b00);
        for (int i = 0; i < 4; i++) begin
            set_st(1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 2'b00);
            step();
        end
        @(negedge clock);
        chk("fill_count", 32'(sb_count), 32'd4);
        chk("fill_ready", 32'(st_ready), 32'd0);
        chk("fill_we",    32'(mem_we),   32'd0);
        chk("fill_addr",  mem_addr,      32'h100);
        set_st(1, 32'h210, 32'hA4, 2'b00);
        step();
        set_st(0, 0, 0, 0);
        set_ld(0, 0, 0);
        @(negedge clock);
        chk("full_count", 32'(sb_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            chk("fill_drain_we",   32'(mem_we), 32'd1);
            chk("fill_drain_addr", mem_addr,    32'h200 + 32'(4 * i));
            chk("fill_drain_data", mem_wdata,   32'hA0 + 32'(i));
            step();
        end
        @(negedge clock);
        chk("fill_done_empty", 32'(sb_empty), 32'd1);
        step();

        // Conflict: SB 0x23 then LW 0x20
        set_st(1, 32'h23, 32'h7F, 2'b10);
        step();
        set_st(0, 0, 0, 0);
        set_ld(1, 32'h20, 2'b00);
        @(negedge clock);
        chk("cf_stall", 32'(ld_stall),   32'd1);
        chk("cf_we",    32'(mem_we),     32'd1);
        chk("cf_addr",  mem_addr,        32'h23);
        chk("cf_data",  mem_wdata,       32'h7F);
        chk("cf_ls",    32'(mem_ls_bit), 32'd2);
        step();
        @(negedge clock);
        chk("cf_release", 32'(ld_stall), 32'd0);
        chk("cf_ld_addr", mem_addr,      32'h20);
        chk("cf_ld_we",   32'(mem_we),   32'd0);
        set_ld(0, 0, 0);
        step();

        // Same queued store, load to another word does not stall
        set_st(1, 32'h23, 32'h7F, 2'b10);
        step();
        set_st(0, 0, 0, 0);
        set_ld(1, 32'h40, 2'b00);
        @(negedge clock);
        chk("nc_stall", 32'(ld_stall), 32'd0);
        chk("nc_addr",  mem_addr,      32'h40);
        chk("nc_count", 32'(sb_count), 32'd1);
        step();
        set_ld(0, 0, 0);
        step();

        // Wrap-around: 10 stores with loads blocking two of every three cycles
        k = 0;
        guard = 0;
        while (k < 10 && guard < 60) begin
            set_st(1, 32'h300 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 2'(k % 3));
            set_ld((guard % 3) != 2, 32'h900, 2'b00);
            step();
            chk("wrap_max", 32'(sb_count <= 3'd4), 32'd1);
            if (last_acc) k++;
            guard++;
        end
        chk("wrap_all_pushed", 32'(k), 32'd10);
        set_st(0, 0, 0, 0);
        set_ld(0, 0, 0);
        repeat (6) step();
        @(negedge clock);
        chk("wrap_empty", 32'(sb_empty), 32'd1);
        step();

        // Simultaneous push and pop at count 2
        set_ld(1, 32'h100, 2'b00);
        set_st(1, 32'h400, 32'h11, 2'b00);
        step();
        set_st(1, 32'h404, 32'h22, 2'b00);
        step();
        set_ld(0, 0, 0);
        set_st(1, 32'h408, 32'h33, 2'b00);
        @(negedge clock);
        chk("pp_count_before", 32'(sb_count), 32'd2);
        chk("pp_drain_addr",   mem_addr,      32'h400);
        chk("pp_drain_data",   mem_wdata,     32'h11);
        step();
        set_st(0, 0, 0, 0);
        @(negedge clock);
        chk("pp_count_after", 32'(sb_count), 32'd2);
        chk("pp_next_addr",   mem_addr,      32'h404);
        repeat (3) step();

        // Asynchronous reset with two entries queued
        set_ld(1, 32'h100, 2'b00);
        set_st(1, 32'h500, 32'h55, 2'b00);
        step();
        set_st(1, 32'h504, 32'h66, 2'b00);
        step();
        set_st(0, 0, 0, 0);
        #3 reset = 1'b1;
        #1;
        chk("rst_count", 32'(sb_count), 32'd0);
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_ready", 32'(st_ready), 32'd1);
        set_ld(0, 0, 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_idle_we",   32'(mem_we), 32'd0);
        chk("rst_idle_addr", mem_addr,    32'h0);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store-drain queue between the EX/MEM pipeline register and the 4 KB data memory. It accepts committed stores (word, half or byte) from the MEM stage and queues them in a small FIFO. It drains them into the data memory one per cycle whenever the memory port is not needed by a load. Loads that hit a word with a pending store are stalled until that store has drained, so memory contents stay program-ordered.

## Interface
- DEPTH, 4, number of queue entries; power of two, 2..16
- clock  in  1  pipeline clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears queue
- st_valid  in  1  MEM stage presents a store this cycle
- st_addr  in  32  store byte address (ALU result)
- st_data  in  32  store data (rs2 register value, unaligned; low bits used for HALF/BYTE)
- st_ls_bit  in  2  00 WORD, 01 HALF, 10 BYTE; 11 treated as WORD
- st_ready  out  1  queue can accept a store this cycle
- ld_valid  in  1  MEM stage presents a load this cycle
- ld_addr  in  32  load byte address
- ld_ls_bit  in  2  load size, passed to memory
- ld_stall  out  1  load must be held; pipeline freezes MEM and earlier
- mem_we  out  1  write strobe to data memory (memory writes on negedge)
- mem_addr  out  32  address to data memory
- mem_wdata  out  32  write data to data memory
- mem_ls_bit  out  2  size to data memory
- sb_count  out  log2(DEPTH)+1  occupied entries
- sb_empty  out  1  sb_count == 0

## Operation
- Entry fields: addr[31:0], data[31:0], ls_bit[1:0]. Storage is a circular array with head (oldest) and tail pointers, each log2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- Push: st_valid && st_ready writes {st_addr, st_data, st_ls_bit} at tail; tail++ and count++.
- st_ready = (count < DEPTH). Full does not accept even if a pop happens in the same cycle. A store offered while full is not accepted; the pipeline must hold it.
- Conflict: ld_conflict = ld_valid && some valid entry has addr[11:2] == ld_addr[11:2]. Only the word index is compared, regardless of size; this is conservative. The incoming store of the same cycle is not compared.
- ld_stall = ld_conflict.
- Port arbitration (combinational, every cycle):
  - LOAD: ld_valid && !ld_conflict. mem_addr = ld_addr, mem_ls_bit = ld_ls_bit, mem_we = 0, mem_wdata = 0. No pop.
  - DRAIN: otherwise, if count > 0. mem_addr/mem_wdata/mem_ls_bit = head entry, mem_we = 1, pop at posedge (head++, count--).
  - IDLE: otherwise. mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_ls_bit = 00.
- A conflicting load therefore yields the port to draining until no matching entry remains. It then proceeds through LOAD.
- Push and pop in the same cycle leave count unchanged. Both pointers advance.
- st_valid and ld_valid both high is a protocol violation. Arbitration is computed as specified, and the store is still pushed if st_ready.
- Stores drain in strict FIFO order. No merging, no reordering.

## Timing
- Reset (async, immediate): head = tail = count = 0. Outputs are then st_ready = 1, ld_stall = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_ls_bit = 00, sb_empty = 1, sb_count = 0. Reset mid-drain discards all queued stores.
- Store accepted at posedge N. It is visible in the queue (count, conflict check) from cycle N+1. Earliest drain is cycle N+1: mem_we high during N+1, memory writes at the negedge of N+1, entry pops at posedge N+2.
- Drain throughput: one entry per cycle when no load is present.
- Conflicting-load stall length: number of cycles until the last matching entry pops, counting the FIFO entries ahead of it. A non-conflicting load never stalls, even with a non-empty queue.
- All outputs except pointer/count state are combinational from registers and current inputs. No output is registered beyond the queue.

## Test plan
- Reset then idle: sb_empty = 1, st_ready = 1, mem_we = 0, mem_addr = 0 for 3 cycles. Assert reset mid-way with 2 entries queued: sb_count = 0 immediately.
- Single SW 0x00000010 <- 0xDEADBEEF with no loads: mem_we = 1 one cycle later with mem_addr = 0x10, mem_wdata = 0xDEADBEEF, mem_ls_bit = 00. Next cycle sb_empty = 1.
- Fill: 4 back-to-back stores while ld_valid with non-conflicting addresses holds the port. sb_count reaches 4 and st_ready = 0. A fifth store is refused, sb_count stays 4. Drop ld_valid: 4 drains in order on 4 consecutive cycles.
- Conflict: queue SB 0x23 <- 0x7F, then LW 0x20. ld_stall = 1 until the SB drains (1 cycle), then LOAD with mem_addr = 0x20, mem_we = 0. Separately, LW 0x40 with the same queue: ld_stall = 0 immediately.
- Wrap-around: 10 stores interleaved with drains at DEPTH = 4. Drain order and data match push order across pointer wrap. sb_count never exceeds 4.
- Simultaneous push and pop with count = 2: sb_count stays 2 and the head entry drains correctly.
